// File: rtl/hash_feeder.sv
// Collects 16 message bytes, runs the external hash engine for a fixed latency,
// then holds the captured hash until the consumer takes it.
module hash_feeder #(
  parameter int HASH_LATENCY = 34,
  parameter int MSG_BYTES    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  input  logic                   flush,
  output logic                   eng_en,
  output logic [8*MSG_BYTES-1:0] eng_msg,
  input  logic [7:0]             eng_hash0,
  input  logic [7:0]             eng_hash1,
  input  logic [7:0]             eng_hash2,
  output logic [7:0]             out_hash0,
  output logic [7:0]             out_hash1,
  output logic [7:0]             out_hash2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic [7:0]             blk_count
);

  typedef enum logic [1:0] {LOAD, RUN, OUT} state_t;

  state_t                 state, state_nx;
  logic [3:0]             byte_idx;
  logic [5:0]             lat_cnt;
  logic [8*MSG_BYTES-1:0] msg;

  logic accept, last_byte, lat_done, handshake;

  // flush wins over a byte offered in the same cycle
  assign accept    = (state == LOAD) && in_valid && !flush;
  assign last_byte = accept && (byte_idx == 4'(MSG_BYTES - 1));
  assign lat_done  = (state == RUN) && (lat_cnt == 6'(HASH_LATENCY - 1));
  assign handshake = (state == OUT) && out_ready;

  assign in_ready = (state == LOAD);
  assign busy     = (state != LOAD);
  assign eng_msg  = msg;

  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD:    if (last_byte) state_nx = RUN;
      RUN:     if (lat_done)  state_nx = OUT;
      OUT:     if (handshake) state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD;
      byte_idx  <= '0;
      lat_cnt   <= '0;
      msg       <= '0;
      eng_en    <= 1'b0;
      out_valid <= 1'b0;
      out_hash0 <= '0;
      out_hash1 <= '0;
      out_hash2 <= '0;
      blk_count <= '0;
    end else begin
      state     <= state_nx;
      // eng_en and out_valid are registered copies of the next state
      eng_en    <= (state_nx == RUN);
      out_valid <= (state_nx == OUT);

      if (state == LOAD) begin
        if (flush) begin
          byte_idx <= '0;
        end else if (in_valid) begin
          msg[{byte_idx, 3'b000} +: 8] <= in_data;
          byte_idx                     <= byte_idx + 4'd1;
        end
      end

      if (state == RUN) lat_cnt <= lat_cnt + 6'd1;
      else              lat_cnt <= '0;

      if (lat_done) begin
        out_hash0 <= eng_hash0;
        out_hash1 <= eng_hash1;
        out_hash2 <= eng_hash2;
      end

      if (handshake) blk_count <= blk_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_hash_feeder.sv
// Randomised bench for hash_feeder with a behavioural engine and message model.
module tb_hash_feeder;
  localparam int LAT = 34;

  logic         clk = 1'b0;
  logic         reset, in_valid, flush, out_ready;
  logic [7:0]   in_data;
  logic         in_ready, eng_en, out_valid, busy;
  logic [127:0] eng_msg;
  logic [7:0]   eng_hash0, eng_hash1, eng_hash2;
  logic [7:0]   out_hash0, out_hash1, out_hash2;
  logic [7:0]   blk_count;

  int errors = 0;
  int checks = 0;

  logic [127:0] model_msg;
  int           model_idx;
  int           exp_blk;
  bit           fixed_mode;
  int           ecnt;

  hash_feeder #(.HASH_LATENCY(LAT), .MSG_BYTES(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .flush(flush),
    .eng_en(eng_en), .eng_msg(eng_msg),
    .eng_hash0(eng_hash0), .eng_hash1(eng_hash1), .eng_hash2(eng_hash2),
    .out_hash0(out_hash0), .out_hash1(out_hash1), .out_hash2(out_hash2),
    .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] ref_hash(input logic [127:0] m);
    logic [7:0] h0, h1, h2;
    h0 = 8'h00; h1 = 8'h00; h2 = 8'h00;
    for (int k = 0; k < 16; k++) begin
      h0 = h0 ^ m[8*k +: 8];
      h1 = h1 + m[8*k +: 8];
      h2 = h2 + 8'((k + 1) * int'(m[8*k +: 8]));
    end
    return {h2, h1 ^ 8'hC3, h0};
  endfunction

  function automatic logic [23:0] exp_hash(input logic [127:0] m);
    if (fixed_mode) return 24'h563412;
    return ref_hash(m);
  endfunction

  // Engine: counter runs while eng_en is high; the result is only correct
  // in the cycle the counter reaches LAT-1, garbage otherwise.
  always @(posedge clk) begin
    if (!eng_en) ecnt <= 0;
    else         ecnt <= ecnt + 1;
  end

  always_comb begin
    logic [23:0] h;
    h = exp_hash(eng_msg);
    if (ecnt != LAT - 1) h = ~h;
    {eng_hash2, eng_hash1, eng_hash0} = h;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_msg = '0; model_idx = 0; exp_blk = 0;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    checks++;
    if (in_ready !== 1'b1 || eng_en !== 1'b0) begin
      errors++;
      $display("FAIL load_cycle: in_ready=%b eng_en=%b required 1/0", in_ready, eng_en);
    end
    in_valid = 1'b1; flush = 1'b0; in_data = b;
    model_msg[8*model_idx +: 8] = b;
    model_idx = (model_idx + 1) % 16;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load_bytes(input logic [127:0] blk, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        in_valid = 1'b0; in_data = 8'($urandom);
        checks++;
        if (in_ready !== 1'b1 || eng_en !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL gap_cycle: in_ready=%b eng_en=%b busy=%b required 1/0/0", in_ready, eng_en, busy);
        end
        @(negedge clk);
      end
      drive_byte(blk[8*i +: 8]);
    end
  endtask

  // Entered on the first RUN cycle; exits on the first LOAD cycle after the handshake.
  task automatic run_and_collect(input int hold_cycles);
    int          en_cycles;
    logic [23:0] eh;
    checks++;
    if (busy !== 1'b1 || eng_en !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL run_entry: busy=%b eng_en=%b in_ready=%b required 1/1/0", busy, eng_en, in_ready);
    end
    en_cycles = 0;
    while (eng_en === 1'b1 && en_cycles < 100) begin
      en_cycles++;
      checks++;
      if (eng_msg !== model_msg) begin
        errors++;
        $display("FAIL run_msg: eng_msg=%h required %h", eng_msg, model_msg);
      end
      in_valid = 1'($urandom_range(0, 1));
      flush    = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (en_cycles != LAT) begin
      errors++;
      $display("FAIL eng_en_len: got %0d cycles required %0d", en_cycles, LAT);
    end
    eh = exp_hash(model_msg);
    for (int c = 0; c <= hold_cycles; c++) begin
      checks++;
      if (out_valid !== 1'b1 || {out_hash2, out_hash1, out_hash0} !== eh ||
          in_ready !== 1'b0 || eng_en !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL out_hold: valid=%b hash=%h rdy=%b en=%b busy=%b required 1/%h/0/0/1",
                 out_valid, {out_hash2, out_hash1, out_hash0}, in_ready, eng_en, busy, eh);
      end
      in_valid  = 1'($urandom_range(0, 1));
      flush     = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = (c == hold_cycles);
      @(negedge clk);
    end
    out_ready = 1'b0; in_valid = 1'b0; flush = 1'b0;
    exp_blk = (exp_blk + 1) % 256;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || eng_en !== 1'b0 ||
        blk_count !== 8'(exp_blk)) begin
      errors++;
      $display("FAIL after_handshake: valid=%b busy=%b rdy=%b en=%b blk=%0d required 0/0/1/0/%0d",
               out_valid, busy, in_ready, eng_en, blk_count, exp_blk);
    end
    checks++;
    if (eng_msg !== model_msg) begin
      errors++;
      $display("FAIL msg_retained: eng_msg=%h required %h", eng_msg, model_msg);
    end
  endtask

  function automatic logic [127:0] rand_block();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r;
  endfunction

  task automatic test_reset();
    do_reset();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || eng_en !== 1'b0 || out_valid !== 1'b0 ||
        {out_hash2, out_hash1, out_hash0} !== 24'h0 || blk_count !== 8'h00 || eng_msg !== 128'h0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b busy=%b en=%b valid=%b hash=%h blk=%h msg=%h",
               in_ready, busy, eng_en, out_valid, {out_hash2, out_hash1, out_hash0}, blk_count, eng_msg);
    end
  endtask

  task automatic test_basic();
    logic [127:0] blk;
    fixed_mode = 1'b1;
    for (int i = 0; i < 16; i++) blk[8*i +: 8] = 8'(i);
    load_bytes(blk, 1'b0);
    checks++;
    if (eng_msg !== 128'h0F0E0D0C0B0A09080706050403020100) begin
      errors++;
      $display("FAIL basic_msg: eng_msg=%h required 0f0e..0100", eng_msg);
    end
    run_and_collect(0);
    fixed_mode = 1'b0;
    for (int n = 0; n < 3; n++) begin
      load_bytes(rand_block(), 1'b0);
      run_and_collect(int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_backpressure();
    load_bytes(rand_block(), 1'b0);
    run_and_collect(10);
  endtask

  task automatic test_flush();
    logic [127:0] blk;
    for (int i = 0; i < 5; i++) drive_byte(8'($urandom));
    in_valid = 1'b1; flush = 1'b1; in_data = 8'hAA;
    model_idx = 0;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_state: rdy=%b busy=%b required 1/0", in_ready, busy);
    end
    for (int i = 0; i < 16; i++) blk[8*i +: 8] = 8'(16 + i);
    load_bytes(blk, 1'b0);
    checks++;
    if (eng_msg[7:0] !== 8'h10 || eng_msg[127:120] !== 8'h1F) begin
      errors++;
      $display("FAIL flush_msg: byte0=%h byte15=%h required 10/1f", eng_msg[7:0], eng_msg[127:120]);
    end
    run_and_collect(1);
  endtask

  task automatic test_gaps();
    load_bytes(rand_block(), 1'b1);
    run_and_collect(2);
  endtask

  task automatic test_reset_mid_run();
    load_bytes(rand_block(), 1'b0);
    for (int c = 0; c < 20; c++) @(negedge clk);
    checks++;
    if (eng_en !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_run_pre: en=%b busy=%b required 1/1", eng_en, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_msg = '0; model_idx = 0; exp_blk = 0;
    checks++;
    if (eng_en !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || blk_count !== 8'h00 ||
        in_ready !== 1'b1 || eng_msg !== 128'h0) begin
      errors++;
      $display("FAIL mid_run_reset: en=%b valid=%b busy=%b blk=%h rdy=%b msg=%h required 0/0/0/00/1/0",
               eng_en, out_valid, busy, blk_count, in_ready, eng_msg);
    end
    load_bytes(rand_block(), 1'b0);
    run_and_collect(0);
  endtask

  task automatic test_reset_mid_out();
    int guard;
    load_bytes(rand_block(), 1'b0);
    guard = 0;
    while (out_valid !== 1'b1 && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b1 || blk_count !== 8'(exp_blk)) begin
      errors++;
      $display("FAIL mid_out_pre: valid=%b blk=%0d required 1/%0d", out_valid, blk_count, exp_blk);
    end
    out_ready = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b0;
    model_msg = '0; model_idx = 0; exp_blk = 0;
    checks++;
    if (out_valid !== 1'b0 || blk_count !== 8'h00 || {out_hash2, out_hash1, out_hash0} !== 24'h0 ||
        busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_out_reset: valid=%b blk=%h hash=%h busy=%b required 0/00/0/0",
               out_valid, blk_count, {out_hash2, out_hash1, out_hash0}, busy);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int n = 0; n < 256; n++) begin
      load_bytes(rand_block(), 1'b0);
      run_and_collect(int'($urandom_range(0, 1)));
    end
    checks++;
    if (blk_count !== 8'h00) begin
      errors++;
      $display("FAIL wrap: blk_count=%0d required 0", blk_count);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    fixed_mode = 1'b0; model_msg = '0; model_idx = 0; exp_blk = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_gaps();
    test_reset_mid_run();
    test_reset_mid_out();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
